// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: write-side burst arbiter sharing one async-FIFO write port
// between two requesters. Each grant covers a whole burst of blenX+1 words;
// ties are broken round-robin.
//
// Build option: define FIFO_WR_ARB_FIXED_PRIO_EN for fixed priority
// (req0 always wins a tie, no last-grant pointer).
//
// Ports:
//   wclk, wrst_n      write clock, async active-low reset
//   req0/req1         burst requests (held until matching gnt rises)
//   blen0/blen1       burst length minus one, sampled on the grant edge
//   data0/data1       current word of each requester
//   wfull             FIFO full flag
//   gnt0/gnt1         registered grant, high for the whole burst
//   ack0/ack1         word accepted (winc & gntX), combinational
//   winc, wdata       FIFO write port, combinational
//   busy              registered, high while a burst is in progress
//   remain            registered, words left in the burst minus one
module fifo_wr_arb #(
    parameter int unsigned DSIZE  = 8,
    parameter int unsigned BLEN_W = 4
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [BLEN_W-1:0] blen0,
    input  logic [BLEN_W-1:0] blen1,
    input  logic [DSIZE-1:0]  data0,
    input  logic [DSIZE-1:0]  data1,
    input  logic              wfull,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic              winc,
    output logic [DSIZE-1:0]  wdata,
    output logic              busy,
    output logic [BLEN_W-1:0] remain
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              busy_q, busy_d;
    logic [BLEN_W-1:0] remain_q, remain_d;
    logic              win1;

`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 1 wins only when requester 0 is idle.
    assign win1 = req1 & ~req0;
`else
    // last_q=1 means requester 1 was granted last; resets to 1 so req0
    // wins the first tie.
    logic last_q, last_d;

    assign win1 = req1 & (~req0 | ~last_q);
`endif

    // FIFO write port and accept strobes follow wfull/data combinationally.
    assign winc  = (state_q == XFER) & ~wfull;
    assign ack0  = winc & gnt0_q;
    assign ack1  = winc & gnt1_q;
    assign wdata = gnt0_q ? data0 : (gnt1_q ? data1 : '0);

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign busy   = busy_q;
    assign remain = remain_q;

    // Next-state: arbitrate in IDLE, count words down in XFER.
    always_comb begin
        state_d  = state_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        busy_d   = busy_q;
        remain_d = remain_q;
`ifndef FIFO_WR_ARB_FIXED_PRIO_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    state_d  = XFER;
                    busy_d   = 1'b1;
                    gnt0_d   = ~win1;
                    gnt1_d   = win1;
                    remain_d = win1 ? blen1 : blen0;
`ifndef FIFO_WR_ARB_FIXED_PRIO_EN
                    last_d   = win1;
`endif
                end
            end
            XFER: begin
                if (winc) begin
                    if (remain_q != '0) begin
                        remain_d = remain_q - BLEN_W'(1);
                    end else begin
                        state_d  = IDLE;
                        gnt0_d   = 1'b0;
                        gnt1_d   = 1'b0;
                        busy_d   = 1'b0;
                        remain_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q  <= IDLE;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            busy_q   <= 1'b0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            busy_q   <= busy_d;
            remain_q <= remain_d;
        end
    end

`ifndef FIFO_WR_ARB_FIXED_PRIO_EN
    // Round-robin pointer.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized bench for fifo_wr_arb against a burst-level reference model:
// the model tracks who owns the write port and how many words are left,
// and each requester's data is a counter advanced on every accepted word.
module tb_fifo_wr_arb;

    localparam int unsigned DSIZE  = 8;
    localparam int unsigned BLEN_W = 4;
    localparam int unsigned NCYC   = 4000;

    logic              wclk = 1'b0;
    logic              wrst_n;
    logic              req0, req1;
    logic [BLEN_W-1:0] blen0, blen1;
    logic [DSIZE-1:0]  data0, data1;
    logic              wfull;
    logic              gnt0, gnt1, ack0, ack1, winc, busy;
    logic [DSIZE-1:0]  wdata;
    logic [BLEN_W-1:0] remain;

    fifo_wr_arb #(.DSIZE(DSIZE), .BLEN_W(BLEN_W)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .req0   (req0),
        .req1   (req1),
        .blen0  (blen0),
        .blen1  (blen1),
        .data0  (data0),
        .data1  (data1),
        .wfull  (wfull),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .ack0   (ack0),
        .ack1   (ack1),
        .winc   (winc),
        .wdata  (wdata),
        .busy   (busy),
        .remain (remain)
    );

    always #5 wclk = ~wclk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int owner = -1;     // -1: port free, else requester index holding it
    int left  = 0;      // words still to be written in the current burst
    int last  = 1;      // requester granted most recently
    int cnt0  = 0;      // words accepted from requester 0
    int cnt1  = 0;      // words accepted from requester 1
    int granted_now;
    int winner;
    int n_bursts = 0;
    int n_ties   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DSIZE-1:0] word0(input int n);
        return DSIZE'(32'h10 + n);
    endfunction

    function automatic logic [DSIZE-1:0] word1(input int n);
        return DSIZE'(32'hA0 + n);
    endfunction

    task automatic check_outputs();
        logic xb;
        logic xw;
        logic [DSIZE-1:0]  xd;
        logic [BLEN_W-1:0] xr;
        xb = (owner >= 0);
        xw = xb && !wfull;
        xr = xb ? BLEN_W'(left - 1) : '0;
        xd = (owner == 0) ? word0(cnt0) : ((owner == 1) ? word1(cnt1) : '0);
        check("gnt0",   32'(gnt0),   32'(owner == 0));
        check("gnt1",   32'(gnt1),   32'(owner == 1));
        check("busy",   32'(busy),   32'(xb));
        check("winc",   32'(winc),   32'(xw));
        check("ack0",   32'(ack0),   32'(xw && owner == 0));
        check("ack1",   32'(ack1),   32'(xw && owner == 1));
        check("remain", 32'(remain), 32'(xr));
        check("wdata",  32'(wdata),  32'(xd));
    endtask

    // Model advance at a clock edge, using the inputs seen at that edge.
    task automatic model_edge();
        granted_now = -1;
        if (!wrst_n) begin
            owner = -1;
            left  = 0;
            last  = 1;
        end else if (owner < 0) begin
            if (req0 || req1) begin
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
                winner = req0 ? 0 : 1;
`else
                if (req0 && req1) begin
                    winner = (last == 0) ? 1 : 0;
                    n_ties++;
                end else begin
                    winner = req0 ? 0 : 1;
                end
`endif
                owner       = winner;
                left        = int'(winner == 0 ? blen0 : blen1) + 1;
                last        = winner;
                granted_now = winner;
                n_bursts++;
            end
        end else if (!wfull) begin
            if (owner == 0) cnt0++;
            else            cnt1++;
            left--;
            if (left == 0) owner = -1;
        end
    endtask

    function automatic logic [BLEN_W-1:0] rand_blen();
        // Bias toward the all-ones maximum and very short bursts.
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            default: return BLEN_W'($urandom_range(0, (1 << BLEN_W) - 1));
        endcase
    endfunction

    task automatic drive_inputs(input int cyc);
        if (granted_now == 0) req0 = 1'b0;
        if (granted_now == 1) req1 = 1'b0;
        if (!req0 && $urandom_range(0, 2) == 0) begin
            req0  = 1'b1;
            blen0 = rand_blen();
        end
        if (!req1 && $urandom_range(0, 2) == 0) begin
            req1  = 1'b1;
            blen1 = rand_blen();
        end
        data0 = word0(cnt0);
        data1 = word1(cnt1);
        // Bursts of full cycles plus sparse random full.
        wfull = ((cyc % 97) >= 90) || ($urandom_range(0, 4) == 0);
        if (!wrst_n) begin
            wrst_n = 1'b1;
        end else if ((cyc % 613) == 300) begin
            // Reset in the middle of traffic, with both requesting.
            wrst_n = 1'b0;
            req0   = 1'b1;
            req1   = 1'b1;
            owner  = -1;
            left   = 0;
            last   = 1;
        end
    endtask

    initial begin
        wrst_n = 1'b0;
        req0   = 1'b1;
        req1   = 1'b1;
        blen0  = 4'd3;
        blen1  = 4'd1;
        data0  = word0(0);
        data1  = word1(0);
        wfull  = 1'b0;

        repeat (2) @(posedge wclk);
        @(negedge wclk);
        check_outputs();

        @(posedge wclk);
        #1;
        wrst_n = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge wclk);
            check_outputs();
            @(posedge wclk);
            model_edge();
            #1;
            drive_inputs(cyc);
        end

        check("bursts_seen", 32'(n_bursts > 100), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Write-side burst arbiter for the async FIFO. It shares the FIFO's single write port (`winc`/`wdata`, throttled by `wfull`) between two requesters. Each requester is granted a whole burst of 1..2^BLEN_W words, and bursts are scheduled round-robin. The block lives entirely in the FIFO write clock domain and drives the FIFO write port directly.

## Interface
- `DSIZE`, 8: data word width; matches the FIFO `DSIZE`.
- `BLEN_W`, 4: burst-length field width; burst length = `blen`+1, range 1..16 at default.

Ports:
- `wclk` in 1: write-domain clock; all state on posedge.
- `wrst_n` in 1: asynchronous, active-low reset.
- `req0`, `req1` in 1: requester wants a burst; held high until its `gnt` rises.
- `blen0`, `blen1` in BLEN_W: burst length minus one; sampled on the grant edge.
- `data0`, `data1` in DSIZE: current word; the requester advances to the next word on the edge where its `ack` is high.
- `wfull` in 1: FIFO full flag.
- `gnt0`, `gnt1` out 1: registered grant; high for the whole burst; at most one is high.
- `ack0`, `ack1` out 1: word-accepted strobe; equals `winc & gntX`.
- `winc` out 1: FIFO write enable (combinational).
- `wdata` out DSIZE: granted requester's data; 0 when nothing is granted.
- `busy` out 1: registered; high in XFER.
- `remain` out BLEN_W: registered; words left in the current burst minus one.

## Operation
- **FSM states:** IDLE and XFER.
- **IDLE:**
  - If `req0` or `req1` is high, arbitrate.
  - Set `gntX` and `busy`, load `remain` ← `blenX`, go to XFER.
  - If neither is high, stay in IDLE.
- **Arbitration:**
  - Single requester: it wins.
  - Both requesting: the requester not granted last wins.
  - Pointer `last` updates at each grant; reset value makes `req0` win the first tie.
- **XFER:**
  - `winc` = !`wfull`.
  - `wdata` = granted `dataX`.
  - `ackX` = `winc`.
  - On each edge with `winc`=1 and `remain`≠0: `remain` decrements.
  - On the edge with `winc`=1 and `remain`=0: clear `gnt`/`busy`, set `remain` ← 0, return to IDLE.
- **Backpressure:** `wfull`=1 in XFER gives `winc`=0 and `ack`=0; `remain` holds; the burst resumes with no loss or duplication.
- **Requests during XFER:** `req` inputs are ignored, including the granted requester dropping `req`. A burst always completes with exactly `blen`+1 writes.
- **Reset mid-burst:** `wrst_n` low immediately forces all registered outputs to 0 and the state to IDLE. `winc`/`ack`/`wdata` go to 0 combinationally. The partial burst is abandoned and `last` is reset.
- **Outside XFER:** `winc`, `ack0`, `ack1` and `wdata` are 0.

## Timing
- All outputs are 0 during and after reset until the first grant.
- **Grant latency:**
  - `req` high before edge N gives `gnt` high after edge N.
  - The first `winc` is in the cycle after edge N, if `wfull`=0.
- **Throughput:** one word per cycle while `wfull`=0. A burst of L words with no stalls holds `gnt` for exactly L cycles.
- **Inter-burst gap:** one IDLE cycle between consecutive bursts (arbitration cycle).
- **Combinational path:** `wfull` → `winc`/`ack`. `wdata` follows `dataX` combinationally. The FIFO samples both on the same `wclk` edge.

## Configuration
- `FIFO_WR_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority; `req0` always wins a tie, and the `last` pointer is not implemented.
  - Undefined (default): round-robin as described above.

## Test plan
1. **Reset:** assert `wrst_n`=0 with `req0`=`req1`=1 and `wfull`=0 → `gnt0`/`gnt1`/`winc`/`ack0`/`ack1`/`busy`/`remain`/`wdata` all 0.
2. **Single burst:** `req0`=1, `blen0`=3, `data0` starts at 0x10 and increments on `ack0`, `wfull`=0 → `gnt0` one edge later, then 4 consecutive `winc` with `wdata`=0x10,0x11,0x12,0x13; `remain` 3→0; `gnt0`/`busy` drop after the 4th write.
3. **Round-robin:** `req0`=`req1`=1 held, `blen0`=`blen1`=1 → grants 0,1,0,1; each burst is 2 writes, separated by exactly 1 idle cycle. With `FIFO_WR_ARB_FIXED_PRIO_EN` → grants 0,0,0,0.
4. **Backpressure:** `blen1`=7, `wfull` high for 5 cycles after the 3rd write → `winc`/`ack1`=0 for those 5 cycles, `remain` holds at 4; exactly 8 writes in total with data in order.
5. **Reset mid-burst:** `blen0`=7, pulse `wrst_n` low after the 2nd write → outputs 0 within the reset cycle; after release with `req0`=`req1`=1 → `gnt0` first.
6. **Max length:** `blen0`=15 (all ones) → exactly 16 writes; `remain` does not wrap; `gnt0` drops after the 16th.
